mem_stage_sram_ctrl: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline. Sits between the EXE/MEM register outputs and the MEM/WB register.
- Drives an external 16-bit-wide SRAM. Each 32-bit load or store takes two half-word accesses, each with configurable wait states.
- Asserts freeze to stall the whole pipeline while an access is in flight. Non-memory instructions pass straight through with zero stall.

---
 rtl/mem_stage_sram_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage of the 5-stage MIPS pipeline with a 16-bit external SRAM port.
// A 32-bit load or store is split into a low and a high half-word access.
// Each half is held for WAIT_CYCLES+1 cycles. While the access is in flight
// the whole pipeline is frozen. Non-memory instructions pass through unstalled.
// Optional feature: define MEM_ACCESS_CNT_EN to build the load/store counters
// rd_count and wr_count. Without it, both outputs are tied to zero.
module mem_stage_sram_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   WB_en_in,
    input  logic                   MEM_R_EN_in,
    input  logic                   MEM_W_EN_in,
    input  logic [31:0]            ALU_result_in,
    input  logic [31:0]            ST_val_in,
    input  logic [31:0]            Dest_in,
    output logic                   WB_en,
    output logic                   MEM_R_EN,
    output logic [31:0]            ALU_result,
    output logic [31:0]            Mem_data,
    output logic [31:0]            Dest,
    output logic                   freeze,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t                 state, state_next;
    logic [3:0]             wait_cnt, wait_cnt_next;
    logic [SRAM_ADDR_W-1:0] addr_next;
    logic [15:0]            dq_next;
    logic                   oe_next;
    logic                   we_n_next;

    logic                   req;
    logic                   is_store;
    logic                   is_load;
    logic [31:0]            word_idx;
    logic [SRAM_ADDR_W-1:0] lo_addr;
    logic [SRAM_ADDR_W-1:0] hi_addr;
    logic                   last_wait;

    // A store takes precedence when both enables are high.
    assign req      = MEM_R_EN_in | MEM_W_EN_in;
    assign is_store = MEM_W_EN_in;
    assign is_load  = MEM_R_EN_in & ~MEM_W_EN_in;

    // Word index relative to the SRAM window. Out-of-range addresses simply wrap.
    assign word_idx = (ALU_result_in - 32'(BASE_ADDR)) >> 2;
    assign lo_addr  = SRAM_ADDR_W'({word_idx, 1'b0});
    assign hi_addr  = SRAM_ADDR_W'({word_idx, 1'b1});

    assign last_wait = (wait_cnt == WAIT_LAST);

    // The EXE/MEM fields go straight through to MEM/WB.
    assign WB_en      = WB_en_in;
    assign MEM_R_EN   = MEM_R_EN_in;
    assign ALU_result = ALU_result_in;
    assign Dest       = Dest_in;

    // The stall is released in DONE, so the pipeline advances on the DONE edge.
    assign freeze = req & (state != DONE);

    // State register and registered SRAM pins. The pins come straight from flops,
    // so they cannot glitch. The asynchronous reset drops the write strobe at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            sram_addr   <= '0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            sram_addr   <= addr_next;
            sram_dq_out <= dq_next;
            sram_dq_oe  <= oe_next;
            sram_we_n   <= we_n_next;
        end
    end

    // Next-state logic. The pin values are decoded from the next state, so the
    // pins line up exactly with the state register they are stored alongside.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        addr_next     = sram_addr;
        dq_next       = sram_dq_out;
        oe_next       = 1'b0;
        we_n_next     = 1'b1;

        case (state)
            IDLE: begin
                if (req) begin
                    state_next    = LOW;
                    wait_cnt_next = 4'd0;
                end
            end
            LOW: begin
                if (last_wait) begin
                    state_next    = HIGH;
                    wait_cnt_next = 4'd0;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            HIGH: begin
                if (last_wait) begin
                    state_next    = DONE;
                    wait_cnt_next = 4'd0;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next == LOW) begin
            addr_next = lo_addr;
            if (is_store) begin
                we_n_next = 1'b0;
                oe_next   = 1'b1;
                dq_next   = ST_val_in[15:0];
            end
        end else if (state_next == HIGH) begin
            addr_next = hi_addr;
            if (is_store) begin
                we_n_next = 1'b0;
                oe_next   = 1'b1;
                dq_next   = ST_val_in[31:16];
            end
        end
    end

    // Load data is captured on the last cycle of each half. Between loads it
    // keeps its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Mem_data <= 32'd0;
        end else if (is_load && last_wait) begin
            if (state == LOW) begin
                Mem_data[15:0] <= sram_dq_in;
            end else if (state == HIGH) begin
                Mem_data[31:16] <= sram_dq_in;
            end
        end
    end

`ifdef MEM_ACCESS_CNT_EN
    logic [31:0] rd_count_reg;
    logic [31:0] wr_count_reg;

    // Count each completed access in its DONE cycle. The counters wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_reg <= 32'd0;
            wr_count_reg <= 32'd0;
        end else if (state == DONE) begin
            if (is_store) begin
                wr_count_reg <= wr_count_reg + 32'd1;
            end else if (is_load) begin
                rd_count_reg <= rd_count_reg + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl (WAIT_CYCLES=1, BASE_ADDR=1024).
// The driver issues instructions, and a word-level reference memory predicts each
// response, which is queued. A monitor pops and compares on every retire
// (freeze low), and also checks the SRAM pin profile of each half-word phase.
`timescale 1ns/1ps
module tb_mem_stage_sram_ctrl;

    localparam int unsigned BASE = 1024;
    localparam int unsigned WC   = 1;
    localparam int unsigned AW   = 18;
    localparam int          ACC  = 2 * (WC + 1);

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] ALU_result_in, ST_val_in, Dest_in;
    logic        WB_en, MEM_R_EN;
    logic [31:0] ALU_result, Mem_data, Dest;
    logic        freeze;
    logic [AW-1:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;
    logic [31:0] rd_count, wr_count;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(WC), .SRAM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in), .Dest_in(Dest_in),
        .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
        .Mem_data(Mem_data), .Dest(Dest), .freeze(freeze),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    // External half-word SRAM device: write on the clock edge while we_n is low,
    // asynchronous read.
    logic [15:0] sram [0:(1<<AW)-1];
    always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
    assign sram_dq_in = sram[sram_addr];

    typedef struct {
        int          kind;       // 0 alu, 1 load, 2 store, 3 both enables (store)
        logic [31:0] alu;
        logic [31:0] dest;
        logic        wb;
        logic        mr;
        logic [31:0] mdata;
        int          frz;
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
        logic [31:0] st;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_load = 32'd0;
    int          exp_rd = 0;
    int          exp_wr = 0;
    bit          abort_run = 1'b0;

    function automatic int unsigned word_of(input logic [31:0] addr);
        return ((addr - BASE) >> 2) & ((1 << (AW - 1)) - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference model: a word-addressed memory, the last loaded word, and
    // load/store tallies.
    task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] dest, input logic wb);
        sb_entry_t   e;
        int unsigned w;
        w       = word_of(addr);
        e.kind  = kind;
        e.alu   = addr;
        e.dest  = dest;
        e.wb    = wb;
        e.mr    = (kind == 1 || kind == 3);
        e.st    = data;
        e.lo    = AW'(w * 2);
        e.hi    = AW'(w * 2 + 1);
        e.frz   = (kind == 0) ? 0 : 1 + ACC;
        if (kind == 0) begin
            e.mdata = last_load;
        end else if (kind == 1) begin
            last_load = ref_mem.exists(w) ? ref_mem[w] : 32'd0;
            e.mdata   = last_load;
            exp_rd++;
        end else begin
            ref_mem[w] = data;
            e.mdata    = last_load;
            exp_wr++;
        end
        sb_q.push_back(e);
        WB_en_in      = wb;
        MEM_R_EN_in   = e.mr;
        MEM_W_EN_in   = (kind >= 2);
        ALU_result_in = addr;
        ST_val_in     = data;
        Dest_in       = dest;
        $display("issue kind=%0d addr=0x%08h data=0x%08h dest=%0d", kind, addr, data, dest);
    endtask

    task automatic wait_retire();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!freeze) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            abort_run = 1'b1;
            $display("FAIL retire_timeout freeze=%0b required 0 within 50 cycles", freeze);
        end
    endtask

    task automatic run_one(input int kind, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] dest, input logic wb);
        if (!abort_run) begin
            @(posedge clk);
            #1;
            issue(kind, addr, data, dest, wb);
            wait_retire();
        end
    endtask

    // Monitor: counts frozen cycles, checks the SRAM pins in every LOW/HIGH cycle,
    // and compares the queued expectation on retire.
    int        frz_cnt = 0;
    bit        pin_ok  = 1'b1;
    string     pin_msg = "";
    sb_entry_t m;
    always @(negedge clk) begin
        if (rst) begin
            frz_cnt = 0;
            pin_ok  = 1'b1;
        end else if (sb_q.size() > 0) begin
            if (freeze) begin
                if (frz_cnt >= 1 && frz_cnt <= ACC && sb_q[0].kind != 0) begin
                    int          j;
                    logic [AW-1:0] ea;
                    logic [15:0] ed;
                    bit          st;
                    j  = frz_cnt - 1;
                    ea = (j < int'(WC + 1)) ? sb_q[0].lo : sb_q[0].hi;
                    ed = (j < int'(WC + 1)) ? sb_q[0].st[15:0] : sb_q[0].st[31:16];
                    st = (sb_q[0].kind >= 2);
                    if (sram_addr !== ea || sram_we_n !== !st || sram_dq_oe !== st ||
                        (st && sram_dq_out !== ed)) begin
                        if (pin_ok)
                            pin_msg = $sformatf("cyc%0d actual addr=%0d we_n=%0b oe=%0b dq=%04h required addr=%0d we_n=%0b oe=%0b dq=%04h",
                                                j, sram_addr, sram_we_n, sram_dq_oe, sram_dq_out, ea, !st, st, ed);
                        pin_ok = 1'b0;
                    end
                end
                frz_cnt++;
            end else begin
                m = sb_q.pop_front();
                check("freeze_cycles", 32'(frz_cnt), 32'(m.frz));
                check("alu_result", ALU_result, m.alu);
                check("dest", Dest, m.dest);
                check("wb_en", 32'(WB_en), 32'(m.wb));
                check("mem_r_en", 32'(MEM_R_EN), 32'(m.mr));
                check("mem_data", Mem_data, m.mdata);
                check("done_we_n", 32'(sram_we_n), 32'd1);
                if (m.kind != 0) begin
                    checks++;
                    if (!pin_ok) begin
                        failures++;
                        $display("FAIL sram_pins %s", pin_msg);
                    end
                end
                if (m.kind >= 2)
                    check("sram_content", {sram[m.hi], sram[m.lo]}, m.st);
                $display("retire kind=%0d alu=0x%08h mem_data=0x%08h freeze_cycles=%0d", m.kind, ALU_result, Mem_data, frz_cnt);
                frz_cnt = 0;
                pin_ok  = 1'b1;
            end
        end
    end

    initial begin
        int          kind;
        logic [31:0] addr;
        logic [31:0] d1;
        logic [31:0] d2;
        bit          hit;
        for (int i = 0; i < (1 << AW); i++) sram[i] = 16'd0;
        rst = 1'b1;
        WB_en_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
        ALU_result_in = 32'd0; ST_val_in = 32'd0; Dest_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq_out", 32'(sram_dq_out), 32'd0);
        check("rst_mem_data", Mem_data, 32'd0);
        check("rst_rd_count", rd_count, 32'd0);
        rst = 1'b0;

        // Directed: store, load back, ALU pass-through, then back-to-back load and store.
        run_one(2, 32'd1028, 32'hDEADBEEF, 32'd5, 1'b0);
        run_one(1, 32'd1028, 32'h0, 32'd6, 1'b1);
        run_one(0, 32'h1234, 32'h0, 32'd7, 1'b1);
        run_one(1, 32'd1028, 32'h0, 32'd8, 1'b1);
        run_one(2, 32'd1032, 32'h0BAD_F00D, 32'd9, 1'b0);
        run_one(1, 32'd1032, 32'h0, 32'd10, 1'b1);

        // Random mix, including addresses outside the window that must wrap.
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = $urandom();
            else addr = BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
            if (kind == 0) addr = $urandom();
            run_one(kind, addr, $urandom(), $urandom_range(0, 31), 1'($urandom_range(0, 1)));
        end

        // Abort a store in its HIGH phase. The high half must keep its old value.
        addr = 32'd1100;
        d1   = 32'hA5A5_1234;
        d2   = 32'h5A5A_9876;
        run_one(2, addr, d1, 32'd1, 1'b0);
        if (!abort_run) begin
            @(posedge clk);
            #1;
            issue(2, addr, d2, 32'd2, 1'b0);
            hit = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (sram_addr == AW'(word_of(addr) * 2 + 1) && !sram_we_n) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("abort_high_seen", 32'(hit), 32'd1);
            rst = 1'b1;
            sb_q.delete();
            ref_mem[word_of(addr)] = {d1[31:16], d2[15:0]};
            last_load = 32'd0;
            exp_rd = 0;
            exp_wr = 0;
            #1;
            check("abort_we_n", 32'(sram_we_n), 32'd1);
            check("abort_oe", 32'(sram_dq_oe), 32'd0);
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
            issue(1, addr, 32'h0, 32'd3, 1'b1);
            wait_retire();
        end

        // A few more accesses after reset, so the counters restart from zero.
        for (int n = 0; n < 12; n++) begin
            kind = int'($urandom_range(0, 3));
            run_one(kind, BASE + 4 * $urandom_range(0, 31), $urandom(), $urandom_range(0, 31), 1'b1);
        end

        @(posedge clk);
        #1;
        MEM_R_EN_in = 1'b0;
        MEM_W_EN_in = 1'b0;
        @(posedge clk);
        #1;
        check("queue_drained", 32'(sb_q.size()), 32'd0);
`ifdef MEM_ACCESS_CNT_EN
        check("rd_count", rd_count, 32'(exp_rd));
        check("wr_count", wr_count, 32'(exp_wr));
`else
        check("rd_count_off", rd_count, 32'd0);
        check("wr_count_off", wr_count, 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
